time_display_scanner: RTL and testbench

- Consumer of the 24-bit packed BCD time bus {msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s} produced by the clock counter chain.
- Captures a tear-free snapshot of the bus once per display frame and time-multiplexes the six digits onto a shared 7-segment bus with one enable per digit.
- Adds per-slot ghosting guard, optional leading-zero blanking of the hour tens digit, blinking separator dots and range checking.
- Sits between the time counter and the board's 7-segment pins.

---
 rtl/time_display_pkg.sv | 39 +++
 rtl/bcd_to_7seg.sv | 15 +
 rtl/time_display_scanner.sv | 118 +++++++++++
 tb/tb_time_display_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/time_display_pkg.sv
// Shared constants for the time display scanner: digit patterns, time-bus field offsets
// and the range check applied to a captured time snapshot.
package time_display_pkg;

    localparam int NUM_DIGITS = 6;
    typedef logic [2:0] digit_idx_t;

    // Nibble offsets inside the packed {msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s} bus.
    localparam int LSB_S_OFS = 0;
    localparam int MSB_S_OFS = 4;
    localparam int LSB_M_OFS = 8;
    localparam int MSB_M_OFS = 12;
    localparam int LSB_H_OFS = 16;
    localparam int MSB_H_OFS = 20;

    // Active-high {g,f,e,d,c,b,a} patterns.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic time_is_bad(input logic [23:0] t);
        logic [3:0] msb_h;
        logic [3:0] lsb_h;
        logic       bad;
        msb_h = t[MSB_H_OFS +: 4];
        lsb_h = t[LSB_H_OFS +: 4];
        bad   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        if (t[MSB_M_OFS +: 4] > 4'd5 || t[MSB_S_OFS +: 4] > 4'd5) bad = 1'b1;
        if (msb_h > 4'd2 || (msb_h == 4'd2 && lsb_h > 4'd3)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble-to-segment decoder; values above 9 render as a dash.
module bcd_to_7seg
    import time_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // NOTE: assigning a default before any branch keeps always_comb from inferring a latch.
    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
    end

endmodule

// File: rtl/time_display_scanner.sv
// Six-digit multiplexed 7-segment driver: synchronises the BCD time bus, takes a
// tear-free snapshot once per frame and scans the digits with an anode guard band.
module time_display_scanner
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter int BLINK_FRAMES   = 83,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] time_bcd,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic        frame_start,
    output logic        bad_time
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] GUARD_END  = DW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam digit_idx_t    IDX_LAST   = digit_idx_t'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_INV    = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0]    AN_INV     = {6{AN_ACTIVE_LOW}};

    logic [23:0]   s1_q, s2_q, snap_q, snap_d;
    logic [DW-1:0] dwell_q, dwell_d;
    digit_idx_t    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    an_q, an_d;
    logic          dp_q, dp_d, frame_start_q, frame_start_d, bad_q, bad_d;

    logic          dwell_wrap, frame_wrap, blank_slot;
    logic [3:0]    cur_nibble;
    logic [6:0]    cur_seg;

    assign cur_nibble = 4'(snap_q >> {idx_q, 2'b00});

    bcd_to_7seg u_dec (
        .bcd_i (cur_nibble),
        .seg_o (cur_seg)
    );

    always_comb begin
        dwell_wrap  = (dwell_q == DWELL_LAST);
        frame_wrap  = dwell_wrap && (idx_q == IDX_LAST);
        dwell_d     = dwell_wrap ? '0 : dwell_q + 1'b1;
        idx_d       = idx_q;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (dwell_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        if (frame_wrap) begin
            // A bus still changing across the two sync stages keeps last frame's snapshot.
            if (s1_q == s2_q) snap_d = s2_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        blank_slot    = (idx_q == IDX_LAST) && blank_lz && (snap_q[MSB_H_OFS +: 4] == 4'd0);
        an_d          = ((dwell_q >= GUARD_END) && !blank_slot) ? (6'd1 << idx_q) : 6'd0;
        an_d          = an_d ^ AN_INV;
        seg_d         = cur_seg ^ SEG_INV;
        dp_d          = (blink_q && (idx_q == 3'd2 || idx_q == 3'd4)) ^ SEG_ACTIVE_LOW;
        frame_start_d = frame_wrap;
        bad_d         = time_is_bad(snap_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            snap_q        <= '0;
            dwell_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            seg_q         <= SEG_OFF ^ SEG_INV;
            an_q          <= AN_INV;
            dp_q          <= SEG_ACTIVE_LOW;
            frame_start_q <= 1'b0;
            bad_q         <= 1'b0;
        end else begin
            s1_q          <= time_bcd;
            s2_q          <= s1_q;
            snap_q        <= snap_d;
            dwell_q       <= dwell_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
            bad_q         <= bad_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;
    assign bad_time    = bad_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Randomised bench for time_display_scanner against a cycle-count reference model.
module tb_time_display_scanner;

    localparam int S  = 4;
    localparam int G  = 1;
    localparam int BF = 2;
    localparam int F  = 6 * S;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] time_bcd;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic        frame_start;
    logic        bad_time;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_edge;
    logic [23:0] snap_m, in_m1, in_m2;

    always #5 clk = ~clk;

    time_display_scanner #(
        .SCAN_DIV       (S),
        .GUARD          (G),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .time_bcd    (time_bcd),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start),
        .bad_time    (bad_time)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, act, expv);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic bad_ref(input logic [23:0] t);
        int hh, mm, ss;
        for (int i = 0; i < 6; i++) if (t[4*i +: 4] > 4'd9) return 1'b1;
        hh = t[23:20] * 10 + t[19:16];
        mm = t[15:12] * 10 + t[11:8];
        ss = t[7:4] * 10 + t[3:0];
        return (hh > 23 || mm > 59 || ss > 59);
    endfunction

    function automatic logic [23:0] rand_time();
        int h, m, s;
        h = $urandom_range(0, 23);
        m = $urandom_range(0, 59);
        s = $urandom_range(0, 59);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        n_edge = 0;
        snap_m = '0;
        in_m1  = '0;
        in_m2  = '0;
    endtask

    task automatic check_off(input string tag);
        check({tag, ".seg"}, 32'(seg), 32'h7F);
        check({tag, ".an"},  32'(an),  32'h3F);
        check({tag, ".dp"},  32'(dp),  32'h1);
        check({tag, ".fs"},  32'(frame_start), 32'h0);
        check({tag, ".bad"}, 32'(bad_time), 32'h0);
    endtask

    // Called at a falling edge: drive one cycle of input, then check the registered outputs.
    task automatic step(input logic [23:0] tv, input logic bl);
        int         k, dwell, idx;
        logic [6:0] exp_seg;
        logic [5:0] exp_an;
        logic       exp_dp, blink_b;
        time_bcd = tv;
        blank_lz = bl;
        @(posedge clk);
        n_edge++;
        #1;
        k       = n_edge - 1;
        dwell   = k % S;
        idx     = (k / S) % 6;
        blink_b = ((((n_edge - 1) / F) / BF) % 2) == 1;
        exp_seg = ~seg_of(snap_m[4*idx +: 4]);
        exp_an  = 6'h3F;
        if (dwell >= G && !(idx == 5 && bl && snap_m[23:20] == 4'd0)) exp_an = ~(6'd1 << idx);
        exp_dp  = !(blink_b && (idx == 2 || idx == 4));
        check("seg", 32'(seg), 32'(exp_seg));
        check("an",  32'(an),  32'(exp_an));
        check("dp",  32'(dp),  32'(exp_dp));
        check("frame_start", 32'(frame_start), 32'(n_edge % F == 0));
        check("bad_time", 32'(bad_time), 32'(bad_ref(snap_m)));
        if (n_edge % F == 0 && in_m1 == in_m2) snap_m = in_m2;
        in_m2 = in_m1;
        in_m1 = tv;
        @(negedge clk);
    endtask

    task automatic hold(input logic [23:0] tv, input logic bl, input int cycles);
        for (int i = 0; i < cycles; i++) step(tv, bl);
    endtask

    task automatic mid_reset();
        #2 reset = 1'b0;
        #1 check_off("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        check_off("mid_rel");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] v;
        logic        bl;
        int          len, burst;
        reset    = 1'b0;
        time_bcd = 24'h235959;
        blank_lz = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_off("rst");
        @(negedge clk);
        reset = 1'b1;
        check_off("rel");

        hold(24'h123456, 1'b0, 3 * F);
        hold(24'h091500, 1'b1, 3 * F);
        hold(24'h091500, 1'b0, 2 * F);
        hold(24'h245900, 1'b0, 2 * F);
        hold(24'h1A0000, 1'b1, 2 * F);
        hold(24'h235959, 1'b1, 2 * F + 2);
        mid_reset();

        hold(24'h111111, 1'b0, F);
        while (n_edge % F != F - 4) step(24'h111111, 1'b0);
        for (int i = 0; i < 8; i++) step(rand_time(), 1'b0);
        hold(24'h222222, 1'b0, 3 * F);

        for (int i = 0; i < 40; i++) begin
            v   = ($urandom_range(0, 3) == 0) ? 24'($urandom) : rand_time();
            bl  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 60);
            if ($urandom_range(0, 3) == 0) begin
                burst = $urandom_range(1, 6);
                for (int j = 0; j < burst; j++) step(24'($urandom), bl);
            end
            hold(v, bl, len);
            if (i == 15 || i == 30) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
